// File: rtl/conv_stream_pkg.sv
// Shared types and defaults for the conv stream driver.
// Optional build macro: READY_THROTTLE_EN (see conv_stream_driver.sv).
package conv_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREFETCH,
    XFER,
    DONE
  } drv_state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_LENX  = 64;
  localparam int DEF_LENF  = 33;

endpackage

// File: rtl/conv_stream_driver_if.sv
// Valid/ready word stream between the driver and a conv engine.
// Master drives data/valid, slave drives ready.
interface conv_stream_driver_if #(
  parameter int WIDTH = 16
);

  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/conv_stream_driver_frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// A read and write of the same address in one cycle returns the old word.
module frame_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // storage is never cleared by reset
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // registered read port, holds when not enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_stream_driver.sv
// Host-side driver: sends one stored x frame, collects the y result stream.
// Define READY_THROTTLE_EN to add LFSR-driven gaps on s_ready_y.
module conv_stream_driver
  import conv_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LENX  = DEF_LENX,
  parameter int LENF  = DEF_LENF,
  parameter int SIZE  = LENX - LENF + 1,
  parameter int LOGX  = $clog2(LENX),
  parameter int LOGY  = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [LOGX-1:0]  load_addr,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic [LOGY-1:0]  res_addr,
  output logic [WIDTH-1:0] res_data,
  output logic [LOGY:0]    rx_count,
  conv_stream_driver_if.master m_x,
  conv_stream_driver_if.slave  s_y
);

  localparam int TW = LOGX + 1;
  localparam int RW = LOGY + 1;
  localparam logic [TW-1:0] TX_END = TW'(LENX);
  localparam logic [RW-1:0] RX_END = RW'(SIZE);

  drv_state_t       state_q, state_d;
  logic [TW-1:0]    tx_cnt_q, tx_cnt_d;
  logic [TW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [RW-1:0]    rx_cnt_q, rx_cnt_d;
  logic             bufv_q, bufv_d;
  logic             mval_q, mval_d;
  logic [WIDTH-1:0] mdat_q, mdat_d;
  logic [WIDTH-1:0] x_rd;

  logic run, go, tx_hs, rx_hs;
  logic out_free, load_out, rd_en;
  logic rx_open, thr_ok;

  assign run      = (state_q == PREFETCH) || (state_q == XFER);
  assign go       = start && !run;
  assign tx_hs    = mval_q && m_x.ready;
  assign out_free = !mval_q || m_x.ready;
  // x buffer read register acts as a one-word skid ahead of m_data_x
  assign load_out = run && out_free && bufv_q;
  assign rd_en    = run && (!bufv_q || load_out) && (rd_ptr_q < TX_END);

`ifdef READY_THROTTLE_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 8,6,5,4
  always_comb begin
    lfsr_d = {lfsr_q[6:0],
              lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // free-running throttle pattern
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign thr_ok = (lfsr_q[1:0] != 2'b00);
`else
  assign thr_ok = 1'b1;
`endif

  assign rx_open   = (state_q == XFER) && (rx_cnt_q < RX_END);
  assign s_y.ready = rx_open && thr_ok;
  assign rx_hs     = s_y.ready && s_y.valid;

  // frame sequencing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = PREFETCH;
      PREFETCH:   state_d = XFER;
      XFER: begin
        if (tx_cnt_q == TX_END && rx_cnt_q == RX_END) begin
          state_d = DONE;
        end
      end
    endcase
  end

  // TX read-ahead and RX counting
  always_comb begin
    tx_cnt_d = tx_cnt_q;
    rd_ptr_d = rd_ptr_q;
    rx_cnt_d = rx_cnt_q;
    bufv_d   = bufv_q;
    mval_d   = mval_q;
    mdat_d   = mdat_q;
    if (go) begin
      tx_cnt_d = '0;
      rd_ptr_d = '0;
      rx_cnt_d = '0;
      bufv_d   = 1'b0;
      mval_d   = 1'b0;
    end else begin
      tx_cnt_d = tx_cnt_q + TW'(tx_hs);
      rd_ptr_d = rd_ptr_q + TW'(rd_en);
      rx_cnt_d = rx_cnt_q + RW'(rx_hs);
      if (rd_en) begin
        bufv_d = 1'b1;
      end else if (load_out) begin
        bufv_d = 1'b0;
      end
      if (load_out) begin
        mval_d = 1'b1;
        mdat_d = x_rd;
      end else if (tx_hs) begin
        mval_d = 1'b0;
      end
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      tx_cnt_q <= '0;
      rd_ptr_q <= '0;
      rx_cnt_q <= '0;
      bufv_q   <= 1'b0;
      mval_q   <= 1'b0;
      mdat_q   <= '0;
    end else begin
      state_q  <= state_d;
      tx_cnt_q <= tx_cnt_d;
      rd_ptr_q <= rd_ptr_d;
      rx_cnt_q <= rx_cnt_d;
      bufv_q   <= bufv_d;
      mval_q   <= mval_d;
      mdat_q   <= mdat_d;
    end
  end

  frame_ram #(
    .WIDTH (WIDTH),
    .DEPTH (LENX),
    .AW    (LOGX)
  ) u_xbuf (
    .clk     (clk),
    .reset   (reset),
    .we_i    (load_en && !run),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q[LOGX-1:0]),
    .rdata_o (x_rd)
  );

  frame_ram #(
    .WIDTH (WIDTH),
    .DEPTH (SIZE),
    .AW    (LOGY)
  ) u_ybuf (
    .clk     (clk),
    .reset   (reset),
    .we_i    (rx_hs),
    .waddr_i (rx_cnt_q[LOGY-1:0]),
    .wdata_i (s_y.data),
    .re_i    (1'b1),
    .raddr_i (res_addr),
    .rdata_o (res_data)
  );

  assign busy      = run;
  assign done      = (state_q == DONE);
  assign rx_count  = rx_cnt_q;
  assign m_x.data  = mdat_q;
  assign m_x.valid = mval_q;

endmodule

// File: tb/tb_conv_stream_driver.sv
// Directed bench for conv_stream_driver.
// Build with +define+READY_THROTTLE_EN to also check throttle gaps.
module tb_conv_stream_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [5:0]  load_addr;
  logic [15:0] load_data;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  res_addr;
  logic [15:0] res_data;
  logic [5:0]  rx_count;

  conv_stream_driver_if #(.WIDTH(16)) mx ();
  conv_stream_driver_if #(.WIDTH(16)) sy ();

  conv_stream_driver dut (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .res_addr  (res_addr),
    .res_data  (res_data),
    .rx_count  (rx_count),
    .m_x       (mx),
    .s_y       (sy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] tx_seen [64];
  logic [15:0] ymem [32];
  int tx_n, rx_n, stall_bad, extra_acc, gaps, first_v;

  task automatic load_x();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      load_en = 1'b1; load_addr = 6'(i); load_data = 16'(i + 1);
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic run_frame(input int rmode, input bit early,
                           input bit extra, input bit poke);
    int cyc;
    bit r, hold_v;
    logic [15:0] hold_d;
    tx_n = 0; rx_n = 0; stall_bad = 0; extra_acc = 0;
    gaps = 0; first_v = -1; hold_v = 0; hold_d = '0;
    for (int i = 0; i < 64; i++) tx_seen[i] = 'x;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 600) begin
      if (hold_v && (mx.valid !== 1'b1 || mx.data !== hold_d)) stall_bad++;
      if (mx.valid === 1'b1 && first_v < 0) first_v = cyc;
      r = (rmode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      mx.ready = r;
      if (mx.valid === 1'b1 && r) begin
        if (tx_n < 64) tx_seen[tx_n] = mx.data;
        tx_n++;
      end
      hold_v = (mx.valid === 1'b1) && !r;
      hold_d = mx.data;
      if (early || tx_n >= 64) begin
        if (rx_n < 32) begin
          sy.valid = 1'b1; sy.data = ymem[rx_n];
        end else if (extra) begin
          sy.valid = 1'b1; sy.data = 16'h7abc;
        end else begin
          sy.valid = 1'b0;
        end
        if (sy.valid && sy.ready === 1'b1) begin
          if (rx_n >= 32) extra_acc++;
          rx_n++;
        end else if (sy.valid && rx_n < 32) begin
          gaps++;
        end
      end
      if (poke && cyc == 10) begin
        start = 1'b1; load_en = 1'b1;
        load_addr = 6'd63; load_data = 16'hdead;
      end else begin
        start = 1'b0; load_en = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    sy.valid = 1'b0; mx.ready = 1'b0; start = 1'b0; load_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_chk++; if (mx.valid !== 1'b0) $display("FAIL reset_mvalid got %b want 0", mx.valid); else n_pass++;
    n_chk++; if (sy.ready !== 1'b0) $display("FAIL reset_sready got %b want 0", sy.ready); else n_pass++;
    n_chk++; if (rx_count !== 6'd0) $display("FAIL reset_rxcount got %0d want 0", rx_count); else n_pass++;
    n_chk++; if (res_data !== 16'd0) $display("FAIL reset_resdata got %h want 0", res_data); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_stream();
    int bad = 0;
    for (int k = 0; k < 32; k++) ymem[k] = 16'(k * 7 + 3);
    run_frame(0, 0, 0, 0);
    for (int i = 0; i < 64; i++) if (tx_seen[i] !== 16'(i + 1)) bad++;
    n_chk++; if (first_v !== 2) $display("FAIL stream_latency got %0d want 2", first_v); else n_pass++;
    n_chk++; if (tx_n !== 64) $display("FAIL stream_txn got %0d want 64", tx_n); else n_pass++;
    n_chk++; if (bad !== 0) $display("FAIL stream_order got %0d bad want 0", bad); else n_pass++;
    n_chk++; if (rx_count !== 6'd32) $display("FAIL stream_rxcount got %0d want 32", rx_count); else n_pass++;
    n_chk++; if (done !== 1'b1) $display("FAIL stream_done got %b want 1", done); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL stream_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_stall();
    int bad = 0;
    run_frame(1, 0, 0, 0);
    for (int i = 0; i < 64; i++) if (tx_seen[i] !== 16'(i + 1)) bad++;
    n_chk++; if (stall_bad !== 0) $display("FAIL stall_stable got %0d moves want 0", stall_bad); else n_pass++;
    n_chk++; if (tx_n !== 64) $display("FAIL stall_txn got %0d want 64", tx_n); else n_pass++;
    n_chk++; if (bad !== 0) $display("FAIL stall_order got %0d bad want 0", bad); else n_pass++;
    n_chk++; if (done !== 1'b1) $display("FAIL stall_done got %b want 1", done); else n_pass++;
  endtask

  task automatic test_result_read();
    for (int k = 0; k < 32; k++) ymem[k] = 16'(k * 11 - 100);
    ymem[0] = 16'hfffb; ymem[1] = 16'h0000; ymem[2] = 16'h7fff;
    run_frame(0, 0, 0, 0);
    res_addr = 5'd0;
    @(negedge clk);
    n_chk++; if (res_data !== 16'hfffb) $display("FAIL read0 got %h want fffb", res_data); else n_pass++;
    res_addr = 5'd1;
    #1;
    n_chk++; if (res_data !== 16'hfffb) $display("FAIL read1_latency got %h want fffb", res_data); else n_pass++;
    @(negedge clk);
    n_chk++; if (res_data !== 16'h0000) $display("FAIL read1 got %h want 0000", res_data); else n_pass++;
    res_addr = 5'd2;
    @(negedge clk);
    n_chk++; if (res_data !== 16'h7fff) $display("FAIL read2 got %h want 7fff", res_data); else n_pass++;
  endtask

  task automatic test_overflow();
    int bad = 0;
    for (int k = 0; k < 32; k++) ymem[k] = 16'(16'h1000 + k);
    run_frame(1, 1, 1, 0);
    for (int a = 0; a < 32; a++) begin
      res_addr = 5'(a);
      @(negedge clk);
      if (res_data !== ymem[a]) bad++;
    end
    n_chk++; if (extra_acc !== 0) $display("FAIL ovf_accepted got %0d want 0", extra_acc); else n_pass++;
    n_chk++; if (rx_count !== 6'd32) $display("FAIL ovf_rxcount got %0d want 32", rx_count); else n_pass++;
    n_chk++; if (bad !== 0) $display("FAIL ovf_ybuf got %0d bad want 0", bad); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int cyc = 0;
    int n = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; mx.ready = 1'b1;
    while (n < 20 && cyc < 200) begin
      if (mx.valid === 1'b1) n++;
      @(negedge clk);
      cyc++;
    end
    n_chk++; if (n !== 20) $display("FAIL abort_reach got %0d want 20", n); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_chk++; if (mx.valid !== 1'b0) $display("FAIL abort_mvalid got %b want 0", mx.valid); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL abort_done got %b want 0", done); else n_pass++;
    reset = 1'b0; mx.ready = 1'b0;
    run_frame(0, 0, 0, 0);
    n_chk++; if (tx_seen[0] !== 16'd1) $display("FAIL abort_restart got %h want 0001", tx_seen[0]); else n_pass++;
    n_chk++; if (tx_n !== 64) $display("FAIL abort_txn got %0d want 64", tx_n); else n_pass++;
  endtask

  task automatic test_busy_ignore();
    int bad = 0;
    for (int k = 0; k < 32; k++) ymem[k] = 16'(16'h2000 - k * 5);
    run_frame(0, 0, 0, 1);
    for (int i = 0; i < 64; i++) if (tx_seen[i] !== 16'(i + 1)) bad++;
    n_chk++; if (tx_n !== 64) $display("FAIL ignore_txn got %0d want 64", tx_n); else n_pass++;
    n_chk++; if (bad !== 0) $display("FAIL ignore_order got %0d bad want 0", bad); else n_pass++;
    n_chk++; if (done !== 1'b1) $display("FAIL ignore_done got %b want 1", done); else n_pass++;
    bad = 0;
    for (int a = 0; a < 32; a++) begin
      res_addr = 5'(a);
      @(negedge clk);
      if (res_data !== ymem[a]) bad++;
    end
    n_chk++; if (bad !== 0) $display("FAIL ignore_ybuf got %0d bad want 0", bad); else n_pass++;
`ifdef READY_THROTTLE_EN
    n_chk++; if (gaps == 0) $display("FAIL throttle_gaps got %0d want >0", gaps); else n_pass++;
`endif
  endtask

  initial begin
    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; res_addr = '0;
    mx.ready = 1'b0; sy.valid = 1'b0; sy.data = '0;
    test_reset();
    load_x();
    test_stream();
    test_stall();
    test_result_read();
    test_overflow();
    test_reset_midframe();
    test_busy_ignore();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
